// File: rtl/invaders_video_fetch.sv
// Space Invaders video fetch stage: raster counters, bitmap/colour-PROM fetch,
// LSB-first pixel shifter, sync/blank flags and the two per-frame CPU interrupts.
// Everything runs on Clock and advances only on ce_pix, except that an
// in-flight RAM fetch always runs to completion.
module invaders_video_fetch #(
   parameter int          H_TOTAL      = 320,
   parameter int          H_ACTIVE     = 256,
   parameter int          V_TOTAL      = 262,
   parameter int          V_ACTIVE     = 224,
   parameter int          HS_START     = 272,
   parameter int          HS_END       = 304,
   parameter int          VS_START     = 234,
   parameter int          VS_END       = 237,
   parameter logic [15:0] VRAM_BASE    = 16'h2400,
   // Lines at which the RST 1 / RST 2 strobes fire (arcade values by default)
   parameter int          IRQ_MID_LINE = 96,
   parameter int          IRQ_END_LINE = 224
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic        ce_pix,
   output logic [15:0] Ram_Addr,
   output logic        Ram_req,
   input  logic [7:0]  Ram_out,
   output logic [10:0] color_prom_addr,
   input  logic [7:0]  color_prom_out,
   output logic        pixel,
   output logic [2:0]  color,
   output logic        hsync,
   output logic        vsync,
   output logic        hblank,
   output logic        vblank,
   output logic        irq_mid,
   output logic        irq_end
);

   // Raster constants narrowed to counter width once, so compares stay 9 bit
   localparam logic [8:0] LP_H_LAST  = 9'(H_TOTAL - 1);
   localparam logic [8:0] LP_V_LAST  = 9'(V_TOTAL - 1);
   localparam logic [8:0] LP_H_EOL   = 9'(H_TOTAL - 4);
   localparam logic [8:0] LP_H_ACT   = 9'(H_ACTIVE);
   localparam logic [8:0] LP_V_ACT   = 9'(V_ACTIVE);
   localparam logic [8:0] LP_HS_S    = 9'(HS_START);
   localparam logic [8:0] LP_HS_E    = 9'(HS_END);
   localparam logic [8:0] LP_VS_S    = 9'(VS_START);
   localparam logic [8:0] LP_VS_E    = 9'(VS_END);
   localparam logic [8:0] LP_IRQ_MID = 9'(IRQ_MID_LINE);
   localparam logic [8:0] LP_IRQ_END = 9'(IRQ_END_LINE);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2
   } fetch_state_t;

   fetch_state_t r_state;

   logic [8:0]  r_hcount;
   logic [8:0]  r_vcount;
   logic        r_hblank;
   logic        r_vblank;
   logic        r_hsync;
   logic        r_vsync;
   logic        r_irq_mid;
   logic        r_irq_end;
   logic [15:0] r_ram_addr;
   logic        r_ram_req;
   logic [10:0] r_prom_addr;
   logic [7:0]  r_hold_byte;
   logic [2:0]  r_hold_col;
   logic [7:0]  r_shift;
   logic [2:0]  r_color;

   logic        w_h_wrap;
   logic [8:0]  w_h_next;
   logic [8:0]  w_v_plus1;
   logic [8:0]  w_v_next;
   logic [6:0]  w_col_sum;
   logic        w_trig_eol;
   logic        w_trig_mid;
   logic [8:0]  w_tgt_line;
   logic [4:0]  w_tgt_col;
   logic        w_fetch_go;
   logic [15:0] w_fetch_addr;
   logic        w_load;
   logic        w_unused_prom;

   // Only the low three PROM bits carry colour
   assign w_unused_prom = ^color_prom_out[7:3];

   // Next raster position, fetch trigger/target and shifter load decision
   always_comb begin
      w_h_wrap   = (r_hcount == LP_H_LAST);
      w_h_next   = w_h_wrap ? 9'd0 : r_hcount + 9'd1;
      w_v_plus1  = (r_vcount == LP_V_LAST) ? 9'd0 : r_vcount + 9'd1;
      w_v_next   = w_h_wrap ? w_v_plus1 : r_vcount;
      // Column whose first pixel lies 4 pixels ahead of the new position
      w_col_sum  = {1'b0, w_h_next[8:3]} + 7'd1;
      // Near end of line the fetch looks ahead to column 0 of the next line
      w_trig_eol = (w_h_next == LP_H_EOL);
      w_trig_mid = (w_h_next[2:0] == 3'd4) && (w_col_sum < 7'd32) && !w_trig_eol;
      if (w_trig_eol) begin
         w_tgt_line = w_v_plus1;
         w_tgt_col  = 5'd0;
      end else begin
         w_tgt_line = w_v_next;
         w_tgt_col  = w_col_sum[4:0];
      end
      w_fetch_go   = ce_pix && (w_trig_eol || w_trig_mid) && (w_tgt_line < LP_V_ACT);
      w_fetch_addr = VRAM_BASE + {2'b00, w_tgt_line, 5'b00000} + {11'd0, w_tgt_col};
      w_load       = (w_h_next[2:0] == 3'd0) && (w_h_next < LP_H_ACT);
   end

   // Raster counters and the flags that are registered alongside them
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         r_hcount <= 9'd0;
         r_vcount <= 9'd0;
         r_hblank <= 1'b0;
         r_vblank <= 1'b0;
         r_hsync  <= 1'b0;
         r_vsync  <= 1'b0;
      end else if (ce_pix) begin
         r_hcount <= w_h_next;
         r_vcount <= w_v_next;
         r_hblank <= (w_h_next >= LP_H_ACT);
         r_vblank <= (w_v_next >= LP_V_ACT);
         r_hsync  <= (w_h_next >= LP_HS_S) && (w_h_next < LP_HS_E);
         r_vsync  <= (w_v_next >= LP_VS_S) && (w_v_next < LP_VS_E);
      end
   end

   // Single-Clock interrupt strobes when the raster enters column 0 of the IRQ lines
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         r_irq_mid <= 1'b0;
         r_irq_end <= 1'b0;
      end else begin
         r_irq_mid <= ce_pix && (w_h_next == 9'd0) && (w_v_next == LP_IRQ_MID);
         r_irq_end <= ce_pix && (w_h_next == 9'd0) && (w_v_next == LP_IRQ_END);
      end
   end

   // Fetch FSM: one address cycle, one data cycle, then release the RAM port
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         r_state     <= ST_IDLE;
         r_ram_addr  <= VRAM_BASE;
         r_ram_req   <= 1'b0;
         r_prom_addr <= 11'd0;
         r_hold_byte <= 8'd0;
         r_hold_col  <= 3'd0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_fetch_go) begin
                  r_ram_addr  <= w_fetch_addr;
                  r_prom_addr <= {w_fetch_addr[12:7], w_fetch_addr[4:0]};
                  r_ram_req   <= 1'b1;
                  r_state     <= ST_ADDR;
               end
            end
            ST_ADDR: begin
               // RAM and PROM register the address on this edge
               r_state <= ST_DATA;
            end
            ST_DATA: begin
               r_hold_byte <= Ram_out;
               r_hold_col  <= color_prom_out[2:0];
               r_ram_req   <= 1'b0;
               r_state     <= ST_IDLE;
            end
            default: begin
               r_ram_req <= 1'b0;
               r_state   <= ST_IDLE;
            end
         endcase
      end
   end

   // Pixel shifter: load at each 8-pixel group start in the active area, else shift right
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         r_shift <= 8'd0;
         r_color <= 3'd0;
      end else if (ce_pix) begin
         if (w_load) begin
            r_shift <= r_hold_byte;
            r_color <= r_hold_col;
         end else begin
            r_shift <= {1'b0, r_shift[7:1]};
         end
      end
   end

   assign Ram_Addr        = r_ram_addr;
   assign Ram_req         = r_ram_req;
   assign color_prom_addr = r_prom_addr;
   assign pixel           = r_shift[0] & ~r_hblank & ~r_vblank;
   assign color           = r_color;
   assign hsync           = r_hsync;
   assign vsync           = r_vsync;
   assign hblank          = r_hblank;
   assign vblank          = r_vblank;
   assign irq_mid         = r_irq_mid;
   assign irq_end         = r_irq_end;

endmodule

// File: tb/tb_invaders_video_fetch.sv
// Scoreboard bench for invaders_video_fetch. A shortened frame (24 lines, full
// 320-pixel width) keeps run time small; the bitmap base is placed so the last
// active read lands on 0x3FFF.
module tb_invaders_video_fetch;

   localparam int          H_TOTAL  = 320;
   localparam int          H_ACTIVE = 256;
   localparam int          V_TOTAL  = 24;
   localparam int          V_ACTIVE = 16;
   localparam int          HS_START = 272;
   localparam int          HS_END   = 304;
   localparam int          VS_START = 18;
   localparam int          VS_END   = 21;
   localparam int          IRQ_MID  = 6;
   localparam int          IRQ_END  = 16;
   localparam logic [15:0] BASE     = 16'h3E00;
   localparam int          FRAME    = H_TOTAL * V_TOTAL;

   logic        clk;
   logic        rst;
   logic        ce_pix;
   logic [15:0] Ram_Addr;
   logic        Ram_req;
   logic [7:0]  ram_q;
   logic [10:0] color_prom_addr;
   logic [7:0]  prom_q;
   logic        pixel;
   logic [2:0]  color;
   logic        hsync, vsync, hblank, vblank, irq_mid, irq_end;

   invaders_video_fetch #(
      .H_TOTAL(H_TOTAL), .H_ACTIVE(H_ACTIVE), .V_TOTAL(V_TOTAL), .V_ACTIVE(V_ACTIVE),
      .HS_START(HS_START), .HS_END(HS_END), .VS_START(VS_START), .VS_END(VS_END),
      .VRAM_BASE(BASE), .IRQ_MID_LINE(IRQ_MID), .IRQ_END_LINE(IRQ_END)
   ) dut (
      .Clock(clk), .Reset(rst), .ce_pix(ce_pix),
      .Ram_Addr(Ram_Addr), .Ram_req(Ram_req), .Ram_out(ram_q),
      .color_prom_addr(color_prom_addr), .color_prom_out(prom_q),
      .pixel(pixel), .color(color), .hsync(hsync), .vsync(vsync),
      .hblank(hblank), .vblank(vblank), .irq_mid(irq_mid), .irq_end(irq_end)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memories with registered, 1-Clock read latency
   logic [7:0] mem  [0:8191];
   logic [7:0] prom [0:2047];
   always @(posedge clk) begin
      ram_q  <= mem[Ram_Addr[12:0]];
      prom_q <= prom[color_prom_addr];
   end

   typedef struct {
      int       h;
      int       v;
      logic     pixel;
      logic [2:0] color;
      bit       chk_color;
      logic     hs, vs, hb, vb, im, ie;
   } exp_t;

   exp_t        exp_q[$];
   logic [15:0] addr_q[$];
   logic [15:0] fetch_at[int];
   exp_t        last_exp;

   int checks = 0;
   int failures = 0;
   int mh, mv;
   bit first_frame;
   bit mon_en;
   int reads, im_cnt, ie_cnt, hs_cnt, vs_cnt;
   logic [15:0] last_read;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h (model line %0d x %0d)", name, act, req, mv, mh);
      end
   endtask

   function automatic logic [15:0] pix_addr(input int v, input int col);
      return 16'(int'(BASE) + v * 32 + col);
   endfunction

   function automatic int prom_index(input logic [15:0] a);
      int ai;
      ai = int'(a);
      return ((ai >> 7) & 63) * 32 + (ai & 31);
   endfunction

   function automatic int rgap();
      return ($urandom_range(3) == 0) ? 1 : 0;
   endfunction

   // Expected outputs at the model's current raster position
   function automatic exp_t make_exp();
      exp_t e;
      logic [7:0]  b;
      logic [2:0]  c;
      logic [15:0] a;
      int col;
      e.h  = mh;
      e.v  = mv;
      e.hb = (mh >= H_ACTIVE);
      e.vb = (mv >= V_ACTIVE);
      e.hs = (mh >= HS_START) && (mh < HS_END);
      e.vs = (mv >= VS_START) && (mv < VS_END);
      e.im = (mv == IRQ_MID) && (mh == 0);
      e.ie = (mv == IRQ_END) && (mh == 0);
      e.chk_color = !e.hb && !e.vb;
      e.pixel = 1'b0;
      e.color = 3'd0;
      if (e.chk_color) begin
         col = mh / 8;
         if (first_frame && mv == 0 && col == 0) begin
            b = 8'd0;
            c = 3'd0;
         end else begin
            a = pix_addr(mv, col);
            b = mem[a[12:0]];
            c = prom[prom_index(a)][2:0];
         end
         e.pixel = b[mh % 8];
         e.color = c;
      end
      return e;
   endfunction

   // One pixel enable: advance the model, queue expectations, pulse ce_pix
   task automatic issue_ce(input int gap);
      exp_t e;
      int p;
      @(negedge clk);
      mh++;
      if (mh == H_TOTAL) begin
         mh = 0;
         mv++;
         if (mv == V_TOTAL) begin
            mv = 0;
            first_frame = 0;
         end
      end
      p = mv * H_TOTAL + mh;
      if (fetch_at.exists(p)) addr_q.push_back(fetch_at[p]);
      e = make_exp();
      exp_q.push_back(e);
      last_exp = e;
      ce_pix = 1'b1;
      @(negedge clk);
      ce_pix = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_ram_addr"}, 32'(Ram_Addr), 32'(BASE));
      chk({tag, "_ram_req"}, 32'(Ram_req), 32'd0);
      chk({tag, "_prom_addr"}, 32'(color_prom_addr), 32'd0);
      chk({tag, "_pixel"}, 32'(pixel), 32'd0);
      chk({tag, "_color"}, 32'(color), 32'd0);
      chk({tag, "_hsync"}, 32'(hsync), 32'd0);
      chk({tag, "_vsync"}, 32'(vsync), 32'd0);
      chk({tag, "_hblank"}, 32'(hblank), 32'd0);
      chk({tag, "_vblank"}, 32'(vblank), 32'd0);
      chk({tag, "_irq"}, 32'({irq_mid, irq_end}), 32'd0);
   endtask

   task automatic clear_counts();
      reads = 0; im_cnt = 0; ie_cnt = 0; hs_cnt = 0; vs_cnt = 0;
   endtask

   task automatic chk_frame(input string tag);
      chk({tag, "_reads"}, 32'(reads), 32'(V_ACTIVE * 32));
      chk({tag, "_last_read"}, 32'(last_read), 32'(BASE));
      chk({tag, "_irq_mid_cnt"}, 32'(im_cnt), 32'd1);
      chk({tag, "_irq_end_cnt"}, 32'(ie_cnt), 32'd1);
      chk({tag, "_hsync_px"}, 32'(hs_cnt), 32'((HS_END - HS_START) * V_TOTAL));
      chk({tag, "_vsync_px"}, 32'(vs_cnt), 32'((VS_END - VS_START) * H_TOTAL));
   endtask

   // Monitor: pops expectations whenever the DUT presents a read or a pixel step
   initial begin : monitor
      logic        ce_s;
      logic        req_prev;
      logic [15:0] ea;
      exp_t        e;
      req_prev = 1'b0;
      forever begin
         @(posedge clk);
         ce_s = ce_pix;
         #1;
         if (!mon_en) begin
            req_prev = Ram_req;
         end else begin
            if (Ram_req && !req_prev) begin
               reads++;
               last_read = Ram_Addr;
               if (addr_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL spurious_read actual=0x%0h required=no read", Ram_Addr);
               end else begin
                  ea = addr_q.pop_front();
                  chk("ram_addr", 32'(Ram_Addr), 32'(ea));
                  chk("prom_addr", 32'(color_prom_addr), 32'(prom_index(ea)));
               end
            end
            req_prev = Ram_req;
            if (ce_s) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL pixel_step actual=output step required=queued expectation");
               end else begin
                  e = exp_q.pop_front();
                  chk("pixel", 32'(pixel), 32'(e.pixel));
                  if (e.chk_color) chk("color", 32'(color), 32'(e.color));
                  chk("hsync", 32'(hsync), 32'(e.hs));
                  chk("vsync", 32'(vsync), 32'(e.vs));
                  chk("hblank", 32'(hblank), 32'(e.hb));
                  chk("vblank", 32'(vblank), 32'(e.vb));
                  chk("irq_mid", 32'(irq_mid), 32'(e.im));
                  chk("irq_end", 32'(irq_end), 32'(e.ie));
               end
               if (hsync) hs_cnt++;
               if (vsync) vs_cnt++;
            end else begin
               chk("irq_mid_idle", 32'(irq_mid), 32'd0);
               chk("irq_end_idle", 32'(irq_end), 32'd0);
            end
            if (irq_mid) im_cnt++;
            if (irq_end) ie_cnt++;
         end
      end
   end

   initial begin : watchdog
      #3_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      int reads_before;
      rst = 1'b1;
      ce_pix = 1'b0;
      mon_en = 1'b0;
      mh = 0; mv = 0; first_frame = 1;
      last_read = 16'd0;
      clear_counts();
      for (int i = 0; i < 8192; i++) mem[i] = 8'($urandom);
      for (int i = 0; i < 2048; i++) prom[i] = 8'($urandom);
      mem[BASE[12:0]] = 8'h01;
      mem[13'(BASE + 16'h0020)] = 8'h80;
      prom[prom_index(BASE + 16'h0055)] = 8'hF5;
      for (int l = 0; l < V_ACTIVE; l++) begin
         for (int c = 0; c < 32; c++) begin
            int idx;
            idx = (l * H_TOTAL + 8 * c - 4 + FRAME) % FRAME;
            fetch_at[idx] = pix_addr(l, c);
         end
      end

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_reset_vals("reset");
      rst = 1'b0;
      mon_en = 1'b1;
      $display("tb: reset released, running frame 1");

      // Frame 1: first frame after reset (line 0 group 0 blank)
      for (int i = 0; i < FRAME; i++) issue_ce(rgap());
      repeat (4) @(negedge clk);
      chk_frame("frame1");
      $display("tb: frame 1 done reads=%0d", reads);
      clear_counts();

      // Frame 2: full data everywhere, with a 100-Clock ce_pix stall mid-line
      for (int i = 0; i < FRAME; i++) begin
         issue_ce(rgap());
         if (mv == 1 && mh == 100) begin
            reads_before = reads;
            repeat (100) @(negedge clk);
            chk("stall_pixel", 32'(pixel), 32'(last_exp.pixel));
            chk("stall_color", 32'(color), 32'(last_exp.color));
            chk("stall_hblank", 32'(hblank), 32'(last_exp.hb));
            chk("stall_hsync", 32'(hsync), 32'(last_exp.hs));
            chk("stall_reads", 32'(reads), 32'(reads_before));
            chk("stall_ram_req", 32'(Ram_req), 32'd0);
            $display("tb: stall of 100 clocks at line 1 x 100 done");
         end
      end
      repeat (4) @(negedge clk);
      chk_frame("frame2");
      $display("tb: frame 2 done reads=%0d", reads);

      // Reset asserted during the DATA cycle of a fetch
      for (int i = 0; i < 43; i++) issue_ce(rgap());
      issue_ce(0);
      @(posedge clk);
      #2;
      chk("data_cycle_req", 32'(Ram_req), 32'd1);
      mon_en = 1'b0;
      rst = 1'b1;
      #1;
      chk("abort_req_low", 32'(Ram_req), 32'd0);
      chk_reset_vals("abort");
      chk("abort_pending_reads", 32'(addr_q.size()), 32'd0);
      exp_q.delete();
      addr_q.delete();
      @(negedge clk);
      rst = 1'b0;
      mh = 0; mv = 0; first_frame = 1;
      clear_counts();
      mon_en = 1'b1;
      $display("tb: reset during DATA applied and released");
      for (int i = 0; i < 8; i++) issue_ce(rgap());
      repeat (3) @(negedge clk);
      chk("post_reset_reads", 32'(reads), 32'd1);
      chk("post_reset_first_addr", 32'(last_read), 32'(BASE + 16'd1));
      for (int i = 0; i < 2 * H_TOTAL; i++) issue_ce(rgap());
      repeat (4) @(negedge clk);
      chk("final_pending_reads", 32'(addr_q.size()), 32'd0);
      chk("final_pending_pixels", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
